// File: rtl/vga_pkg.sv
// Shared constants and FSM state type for the sprite movement controller.
// Screen is 640x480 and coordinates are 10 bits wide.
package vga_pkg;
  localparam int HD      = 640;
  localparam int VD      = 480;
  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;
endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one raw push-button level.
// The async active-low reset clears both stages.
module btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/sprite_move_ctrl.sv
// Per-frame sprite movement: sticky button flags, IDLE/CALC/COMMIT FSM.
// Define SPRITE_WRAP_EN to wrap at screen limits instead of clamping.
module sprite_move_ctrl
  import vga_pkg::*;
#(
  parameter int INIT_X   = 100,
  parameter int INIT_Y   = 150,
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic [1:0]         speed,
  input  logic               freeze,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               upd,
  output logic               busy,
  output logic [7:0]         frame_cnt
);
  localparam logic signed [COORD_W:0] X_MAX =
    (COORD_W+1)'(HD - SPRITE_W);
  localparam logic signed [COORD_W:0] Y_MAX =
    (COORD_W+1)'(VD - SPRITE_H);

  state_t st;
  logic s_up, s_dn, s_lt, s_rt;
  logic f_up, f_dn, f_lt, f_rt;
  logic [3:0] step;
  logic signed [COORD_W:0] stp, dx, dy, sx, sy;
  logic [COORD_W-1:0] nx, ny;

  btn_sync u_up (.clk(clk), .reset(reset), .d(btn_up),    .q(s_up));
  btn_sync u_dn (.clk(clk), .reset(reset), .d(btn_down),  .q(s_dn));
  btn_sync u_lt (.clk(clk), .reset(reset), .d(btn_left),  .q(s_lt));
  btn_sync u_rt (.clk(clk), .reset(reset), .d(btn_right), .q(s_rt));

  function automatic logic [COORD_W-1:0] lim(
    input logic signed [COORD_W:0] v,
    input logic signed [COORD_W:0] mx
  );
`ifdef SPRITE_WRAP_EN
    if (v < 0)       return mx[COORD_W-1:0];
    else if (v > mx) return '0;
    else             return v[COORD_W-1:0];
`else
    if (v < 0)       return '0;
    else if (v > mx) return mx[COORD_W-1:0];
    else             return v[COORD_W-1:0];
`endif
  endfunction

  assign step = 4'd1 << speed;
  assign stp  = $signed({{(COORD_W-3){1'b0}}, step});

  // Opposing directions cancel; freeze cancels everything.
  always_comb begin
    dx = '0;
    dy = '0;
    if (!freeze) begin
      if (f_rt && !f_lt)      dx = stp;
      else if (f_lt && !f_rt) dx = -stp;
      if (f_dn && !f_up)      dy = stp;
      else if (f_up && !f_dn) dy = -stp;
    end
  end

  assign sx   = $signed({1'b0, pos_x}) + dx;
  assign sy   = $signed({1'b0, pos_y}) + dy;
  assign busy = (st != ST_IDLE);

  // Presses landing in the commit cycle are dropped with that commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {f_up, f_dn, f_lt, f_rt} <= 4'b0;
    end else if (st == ST_COMMIT) begin
      {f_up, f_dn, f_lt, f_rt} <= 4'b0;
    end else begin
      f_up <= f_up | s_up;
      f_dn <= f_dn | s_dn;
      f_lt <= f_lt | s_lt;
      f_rt <= f_rt | s_rt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= ST_IDLE;
      pos_x     <= COORD_W'(INIT_X);
      pos_y     <= COORD_W'(INIT_Y);
      nx        <= COORD_W'(INIT_X);
      ny        <= COORD_W'(INIT_Y);
      upd       <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      upd <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          if (frame_start) st <= ST_CALC;
        end
        ST_CALC: begin
          nx <= lim(sx, X_MAX);
          ny <= lim(sy, Y_MAX);
          st <= ST_COMMIT;
        end
        ST_COMMIT: begin
          pos_x     <= nx;
          pos_y     <= ny;
          upd       <= 1'b1;
          frame_cnt <= frame_cnt + 8'd1;
          st        <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_move_ctrl.sv
// Directed bench for sprite_move_ctrl: table of frames plus corner sequences.
// A second instance starts near the screen edges for limit checks.
module tb_sprite_move_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic frame_start = 1'b0;
  logic [3:0] b1 = 4'b0;
  logic [3:0] b2 = 4'b0;
  logic [1:0] speed = 2'd0;
  logic freeze = 1'b0;
  logic [9:0] x1, y1, x2, y2;
  logic upd1, upd2, busy1, busy2;
  logic [7:0] cnt1, cnt2;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sprite_move_ctrl dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .btn_up(b1[3]), .btn_down(b1[2]),
    .btn_left(b1[1]), .btn_right(b1[0]),
    .speed(speed), .freeze(freeze),
    .pos_x(x1), .pos_y(y1), .upd(upd1), .busy(busy1),
    .frame_cnt(cnt1)
  );

  sprite_move_ctrl #(.INIT_X(3), .INIT_Y(462)) dut2 (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .btn_up(b2[3]), .btn_down(b2[2]),
    .btn_left(b2[1]), .btn_right(b2[0]),
    .speed(speed), .freeze(freeze),
    .pos_x(x2), .pos_y(y2), .upd(upd2), .busy(busy2),
    .frame_cnt(cnt2)
  );

  typedef struct {
    logic [3:0] b;
    logic [1:0] spd;
    logic       frz;
    int         ex;
    int         ey;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Buttons b = {up,down,left,right}; ends one cycle after the commit edge.
  task automatic run_frame(input logic [3:0] p1, input logic [3:0] p2,
                           input logic [1:0] spd, input logic frz);
    b1 = p1;
    b2 = p2;
    speed = spd;
    freeze = frz;
    repeat (4) @(negedge clk);
    b1 = 4'b0;
    b2 = 4'b0;
    repeat (3) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int ups;
    int wx1, wy2, wy3;

    tv[0] = '{4'b0000, 2'd0, 1'b0, 100, 150};
    tv[1] = '{4'b0100, 2'd2, 1'b0, 100, 154};
    tv[2] = '{4'b1100, 2'd3, 1'b0, 100, 154};
    tv[3] = '{4'b0001, 2'd3, 1'b0, 108, 154};
    tv[4] = '{4'b0010, 2'd0, 1'b0, 107, 154};
    tv[5] = '{4'b1000, 2'd1, 1'b0, 107, 152};
    tv[6] = '{4'b0011, 2'd1, 1'b0, 107, 152};
    tv[7] = '{4'b0001, 2'd3, 1'b1, 107, 152};
    tv[8] = '{4'b0000, 2'd3, 1'b0, 107, 152};
    tv[9] = '{4'b1010, 2'd2, 1'b0, 103, 148};

`ifdef SPRITE_WRAP_EN
    wy2 = 0; wx1 = 624; wy3 = 8;
`else
    wy2 = 464; wx1 = 0; wy3 = 464;
`endif

    repeat (3) @(negedge clk);
    chk("rst_x", int'(x1), 100);
    chk("rst_y", int'(y1), 150);
    chk("rst_upd", int'(upd1), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_cnt", int'(cnt1), 0);
    reset = 1'b1;

    ups = 0;
    repeat (6) begin
      @(negedge clk);
      ups += int'(upd1) + int'(busy1);
    end
    chk("idle_no_frame", ups, 0);

    for (int i = 0; i < 10; i++) begin
      run_frame(tv[i].b, 4'b0, tv[i].spd, tv[i].frz);
      chk($sformatf("v%0d_upd", i), int'(upd1), 1);
      chk($sformatf("v%0d_x", i), int'(x1), tv[i].ex);
      chk($sformatf("v%0d_y", i), int'(y1), tv[i].ey);
      chk($sformatf("v%0d_cnt", i), int'(cnt1), i + 1);
      @(negedge clk);
      chk($sformatf("v%0d_upd_off", i), int'(upd1), 0);
    end

    run_frame(4'b0, 4'b0100, 2'd3, 1'b0);
    chk("edge_y_down", int'(y2), wy2);
    chk("edge_x_hold", int'(x2), 3);
    run_frame(4'b0, 4'b0010, 2'd2, 1'b0);
    chk("edge_x_left", int'(x2), wx1);
    chk("edge_y_hold", int'(y2), wy2);
    run_frame(4'b0, 4'b0100, 2'd3, 1'b0);
    chk("edge_y_again", int'(y2), wy3);
    chk("dut1_still_x", int'(x1), 103);

    b1 = 4'b0001;
    speed = 2'd0;
    freeze = 1'b0;
    repeat (4) @(negedge clk);
    b1 = 4'b0;
    repeat (3) @(negedge clk);
    frame_start = 1'b1;
    ups = 0;
    @(negedge clk);
    chk("dbl_busy", int'(busy1), 1);
    @(negedge clk);
    frame_start = 1'b0;
    repeat (8) begin
      @(negedge clk);
      ups += int'(upd1);
    end
    chk("dbl_one_upd", ups, 1);
    chk("dbl_x", int'(x1), 104);

    b1 = 4'b0001;
    speed = 2'd3;
    repeat (4) @(negedge clk);
    b1 = 4'b0;
    repeat (3) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("calc_busy", int'(busy1), 1);
    reset = 1'b0;
    #1;
    chk("abort_x", int'(x1), 100);
    chk("abort_y", int'(y1), 150);
    chk("abort_busy", int'(busy1), 0);
    @(negedge clk);
    reset = 1'b1;
    ups = 0;
    repeat (5) begin
      @(negedge clk);
      ups += int'(upd1);
    end
    chk("abort_no_commit", ups, 0);
    chk("abort_cnt", int'(cnt1), 0);

    run_frame(4'b0000, 4'b0, 2'd0, 1'b0);
    chk("fresh_upd", int'(upd1), 1);
    chk("fresh_cnt", int'(cnt1), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
